// File: rtl/pulse_meter.sv
// Pulse train meter: synchronises an asynchronous pulse input and reports the high and low
// lengths of each complete period in sys_clk cycles, with a one-cycle valid strobe.
module pulse_meter #(
    parameter int unsigned W           = 4,
    parameter int unsigned SYNC_STAGES = 2   // 2 or 3
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_ni,
    input  logic         pulse_i,
    output logic [W-1:0] m_meas_o,
    output logic [W-1:0] n_meas_o,
    output logic         meas_valid_o,
    output logic         meas_ovf_o,
    output logic         locked_o
);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    localparam logic [W-1:0] CntMax = '1;
    localparam logic [W-1:0] CntOne = W'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pulse_d_q;
    logic [W-1:0]           cnt_q, cnt_d;
    logic [W-1:0]           high_lat_q, high_lat_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [W-1:0]           m_meas_q, m_meas_d;
    logic [W-1:0]           n_meas_q, n_meas_d;
    logic                   meas_ovf_q, meas_ovf_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   locked_q, locked_d;

    logic pulse_s;
    logic rise;
    logic fall;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], pulse_i};
    assign pulse_s = sync_q[SYNC_STAGES-1];
    assign rise    = pulse_s & ~pulse_d_q;
    assign fall    = ~pulse_s & pulse_d_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        high_lat_d   = high_lat_q;
        ovf_acc_d    = ovf_acc_q;
        m_meas_d     = m_meas_q;
        n_meas_d     = n_meas_q;
        meas_ovf_d   = meas_ovf_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;

        // Any edge restarts the level count at 1 so a level of L cycles reads L at its end.
        if (rise || fall) begin
            cnt_d = CntOne;
        end else if (cnt_q == CntMax) begin
            ovf_acc_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CntOne;
        end

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    ovf_acc_d = 1'b0;
                    state_d   = StHigh;
                end
            end
            StHigh: begin
                if (fall) begin
                    high_lat_d = cnt_q;
                    state_d    = StLow;
                end
            end
            StLow: begin
                if (rise) begin
                    m_meas_d     = high_lat_q;
                    n_meas_d     = cnt_q;
                    meas_ovf_d   = ovf_acc_q;
                    meas_valid_d = 1'b1;
                    locked_d     = 1'b1;
                    ovf_acc_d    = 1'b0;
                    state_d      = StHigh;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q      <= StIdle;
            sync_q       <= '0;
            pulse_d_q    <= 1'b0;
            cnt_q        <= '0;
            high_lat_q   <= '0;
            ovf_acc_q    <= 1'b0;
            m_meas_q     <= '0;
            n_meas_q     <= '0;
            meas_ovf_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            pulse_d_q    <= pulse_s;
            cnt_q        <= cnt_d;
            high_lat_q   <= high_lat_d;
            ovf_acc_q    <= ovf_acc_d;
            m_meas_q     <= m_meas_d;
            n_meas_q     <= n_meas_d;
            meas_ovf_q   <= meas_ovf_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign m_meas_o     = m_meas_q;
    assign n_meas_o     = n_meas_q;
    assign meas_ovf_o   = meas_ovf_q;
    assign meas_valid_o = meas_valid_q;
    assign locked_o     = locked_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: each driven rise queues the hand-computed report for the
// period it closes; a negedge monitor pops and compares on every meas_valid strobe.
module tb_pulse_meter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse = 1'b0;
    logic [3:0] m_meas;
    logic [3:0] n_meas;
    logic       meas_valid;
    logic       meas_ovf;
    logic       locked;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] n;
        logic       o;
    } exp_t;

    exp_t q[$];
    exp_t prev;
    bit   have_prev = 1'b0;
    int   checks    = 0;
    int   passes    = 0;

    pulse_meter #(
        .W          (4),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_ni  (rst_n),
        .pulse_i     (pulse),
        .m_meas_o    (m_meas),
        .n_meas_o    (n_meas),
        .meas_valid_o(meas_valid),
        .meas_ovf_o  (meas_ovf),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && meas_valid) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got meas_valid=1 (m=%0d n=%0d), expected 0 (t=%0t)",
                         m_meas, n_meas, $time);
            end else begin
                e = q.pop_front();
                check("m_meas", int'(m_meas), int'(e.m));
                check("n_meas", int'(n_meas), int'(e.n));
                check("meas_ovf", int'(meas_ovf), int'(e.o));
                check("locked", int'(locked), 1);
            end
        end
    end

    // One period: high h cycles then low l cycles; em/en/eo is what it must report later.
    task automatic period(input int h, input int l, input logic [3:0] em, input logic [3:0] en,
                          input logic eo, input bit lat);
        @(negedge clk);
        pulse = 1'b1;
        if (have_prev) q.push_back(prev);
        prev      = '{m: em, n: en, o: eo};
        have_prev = 1'b1;
        for (int i = 1; i < h; i++) begin
            @(negedge clk);
            if (lat && i == 2) check("latency_early", int'(meas_valid), 0);
            if (lat && i == 3) check("latency_3edges", int'(meas_valid), 1);
        end
        @(negedge clk);
        pulse = 1'b0;
        for (int i = 1; i < l; i++) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_m_meas"}, int'(m_meas), 0);
        check({tag, "_n_meas"}, int'(n_meas), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_meas_ovf"}, int'(meas_ovf), 0);
        check({tag, "_locked"}, int'(locked), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with pulse toggling
        repeat (3) begin
            @(negedge clk);
            pulse = ~pulse;
        end
        check_cleared("reset");
        pulse = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        repeat (6) period(1, 1, 4'd1, 4'd1, 1'b0, 1'b0);
        repeat (4) period(3, 1, 4'd3, 4'd1, 1'b0, 1'b0);
        repeat (4) period(1, 3, 4'd1, 4'd3, 1'b0, 1'b0);
        period(5, 5, 4'd5, 4'd5, 1'b0, 1'b0);
        period(5, 5, 4'd5, 4'd5, 1'b0, 1'b1);

        // Saturation, then stuck-high after lock
        period(20, 2, 4'd15, 4'd2, 1'b1, 1'b0);
        period(2, 2, 4'd2, 4'd2, 1'b0, 1'b0);
        period(2, 2, 4'd2, 4'd2, 1'b0, 1'b0);
        period(40, 2, 4'd15, 4'd2, 1'b1, 1'b0);
        check("stuck_hold_m", int'(m_meas), 2);
        check("stuck_hold_n", int'(n_meas), 2);
        check("stuck_hold_ovf", int'(meas_ovf), 0);
        period(2, 2, 4'd2, 4'd2, 1'b0, 1'b0);
        period(2, 2, 4'd2, 4'd2, 1'b0, 1'b0);

        // Rise closing the last 2/2 period, then reset mid-way through a 5-cycle high
        @(negedge clk);
        pulse = 1'b1;
        q.push_back(prev);
        have_prev = 1'b0;
        repeat (4) @(negedge clk);
        check("drained_pre_reset", q.size(), 0);
        #1 rst_n = 1'b0;
        #1 check_cleared("async_reset");
        pulse = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        period(5, 5, 4'd5, 4'd5, 1'b0, 1'b0);
        check("no_lock_first_period", int'(locked), 0);
        period(5, 5, 4'd5, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        pulse = 1'b1;
        q.push_back(prev);
        have_prev = 1'b0;
        repeat (6) @(negedge clk);
        check("drained_final", q.size(), 0);
        check("locked_final", int'(locked), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
